// File: rtl/pipe_pkg.sv
// Shared types and helpers for the parametrised inter-stage pipeline register.
// The skid state type is only used when PIPE_STAGE_SKID_EN is defined.
package pipe_pkg;

  typedef enum logic [0:0] {
    SKID_EMPTY = 1'b0,
    SKID_FULL  = 1'b1
  } pipe_skid_state_t;

  localparam int unsigned PIPE_WIDTH_DEF = 32;
  localparam int unsigned PIPE_LANES_DEF = 3;
  localparam int unsigned PIPE_MAX_BUS   = 1024;

  // Lane k of a packed payload bus (lane 0 in the LSBs), zero-extended.
  function automatic logic [PIPE_MAX_BUS-1:0] lane_slice(
    input logic [PIPE_MAX_BUS-1:0] bus,
    input int unsigned             k,
    input int unsigned             w
  );
    logic [PIPE_MAX_BUS-1:0] mask;
    mask = (w >= PIPE_MAX_BUS) ? '1 : ((PIPE_MAX_BUS'(1) << w) - PIPE_MAX_BUS'(1));
    return (bus >> (k * w)) & mask;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with a registered threshold flag.
// Counts while i_inc is high, clears to zero on any cycle it is low.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LIMIT = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_hit
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(LIMIT);

  logic [CNT_W-1:0] r_cnt;
  logic             r_hit;
  logic [CNT_W-1:0] w_next;

  always_comb begin
    w_next = '0;
    if (i_inc) begin
      w_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    end
  end

  // Flag is computed from the next count so it lands on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_hit <= 1'b0;
    end else begin
      r_cnt <= w_next;
      r_hit <= (w_next >= CNT_LIM);
    end
  end

  assign o_cnt = r_cnt;
  assign o_hit = r_hit;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline register with stall hold, flush bubble, upstream ready and a
// stall-duration counter. Define PIPE_STAGE_SKID_EN for the one-entry skid buffer.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH       = PIPE_WIDTH_DEF,
  parameter int unsigned LANES       = PIPE_LANES_DEF,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned STALL_LIMIT = 200
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]       stall_cnt_o,
  output logic                   hang_o
);

  localparam int unsigned BUS_W = LANES * WIDTH;

  logic             w_cnt_inc;
  logic             w_load_valid;
  logic [BUS_W-1:0] w_load_data;
  logic             r_out_valid;
  logic [BUS_W-1:0] r_out_data;

  // A flush cycle never counts as stalled, even when stall_i is high.
  assign w_cnt_inc = stall_i & ~flush_i;

  pipe_sat_counter #(
    .CNT_W (CNT_W),
    .LIMIT (STALL_LIMIT)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_cnt_inc),
    .o_cnt (stall_cnt_o),
    .o_hit (hang_o)
  );

`ifdef PIPE_STAGE_SKID_EN
  pipe_skid_state_t r_skid_state;
  logic [BUS_W-1:0] r_skid_data;
  logic             w_skid_capture;

  // Upstream still sees ready during the first stall cycle; that word parks here.
  assign w_skid_capture = ~flush_i & stall_i & in_valid & (r_skid_state == SKID_EMPTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_state <= SKID_EMPTY;
    end else if (flush_i) begin
      r_skid_state <= SKID_EMPTY;
    end else if (stall_i) begin
      if (w_skid_capture) begin
        r_skid_state <= SKID_FULL;
      end
    end else begin
      r_skid_state <= SKID_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (w_skid_capture) begin
      r_skid_data <= in_data;
    end
  end

  assign in_ready = (r_skid_state == SKID_EMPTY);

  // A full skid drains first; in_ready was low, so in_valid is ignored then.
  always_comb begin
    w_load_valid = in_valid;
    w_load_data  = in_valid ? in_data : '0;
    if (r_skid_state == SKID_FULL) begin
      w_load_valid = 1'b1;
      w_load_data  = r_skid_data;
    end
  end
`else
  assign in_ready = ~stall_i;

  always_comb begin
    w_load_valid = in_valid;
    w_load_data  = in_valid ? in_data : '0;
  end
`endif

  // Output stage: flush beats stall beats load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (!stall_i) begin
      r_out_valid <= w_load_valid;
      r_out_data  <= w_load_data;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage core, replacing the per-boundary fixed-field registers with one reusable block. It carries `LANES` payload fields of `WIDTH` bits plus a valid bit, and supports stall (hold), flush (bubble), and an upstream ready handshake. A saturating stall-duration counter feeds the hazard unit. An optional one-entry skid buffer decouples upstream ready from the downstream stall.

## Interface
Parameters:
- `WIDTH`, 32, bits per lane.
- `LANES`, 3, number of payload fields (e.g. PC, Instr, PC+4).
- `CNT_W`, 8, stall counter width.
- `STALL_LIMIT`, 200, threshold for `hang_o`; must be ≤ 2^CNT_W−1.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `stall_i`  in  1  downstream stall (hazard unit); hold outputs.
- `flush_i`  in  1  convert stage to bubble.
- `in_valid`  in  1  upstream word valid.
- `in_data`  in  LANES*WIDTH  upstream payload, lane 0 in LSBs.
- `in_ready`  out  1  upstream word accepted when `in_valid & in_ready`.
- `out_valid`  out  1  registered valid.
- `out_data`  out  LANES*WIDTH  registered payload.
- `stall_cnt_o`  out  CNT_W  consecutive stalled cycles, saturating.
- `hang_o`  out  1  `stall_cnt_o >= STALL_LIMIT`.

## Operation
- Reset (`rst_n`=0, asynchronous): `out_valid`=0, `out_data`=0, `stall_cnt_o`=0, `hang_o`=0, skid empty. Without skid, `in_ready` = `~stall_i` (combinational).
- Priority per edge: flush > stall > load. Flush overrides stall.
- Flush: `out_valid`←0, `out_data`←0, skid emptied. A word presented with `in_ready`=1 in the flush cycle is dropped.
- Stall (no flush): `out_valid`/`out_data` hold.
- Load (no flush, no stall): `out_valid`←`in_valid`; `out_data`←`in_data` if `in_valid`, else 0.
- Stall counter: increments on each edge with `stall_i`=1 and `flush_i`=0, saturating at 2^CNT_W−1. Clears to 0 on any other edge. `hang_o` is registered alongside it.
- Non-stall load with `in_valid`=0 is a normal bubble, not an error.

## Timing
- Latency: 1 cycle, `in_data` to `out_data`.
- Without skid: `in_ready` follows `stall_i` in the same cycle (combinational path). Upstream must hold `in_data` while `in_ready`=0.
- With skid: `in_ready` is registered, equal to skid-empty (no combinational path from `stall_i`).
- Simultaneous stall and flush: flush wins. The counter clears.
- Reset mid-stall: everything clears asynchronously. The counter restarts from 0.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: a one-entry skid buffer with states SKID_EMPTY and SKID_FULL.
  - SKID_EMPTY → SKID_FULL: `stall_i`=1, no flush, `in_valid`=1. The word is captured into skid and `in_ready` drops next cycle.
  - SKID_FULL → SKID_EMPTY: `stall_i`=0, no flush. `out_data`←skid, `out_valid`←1.
  - SKID_FULL → SKID_EMPTY on flush. The skid contents are discarded.
  - No word is lost or duplicated across any stall pattern.
- Undefined: no skid storage; `in_ready`=`~stall_i`.

## Structure
- Package `pipe_pkg`:
  - `pipe_skid_state_t` enum (SKID_EMPTY, SKID_FULL).
  - Default `WIDTH`/`LANES` constants.
  - Function returning the slice for lane *k*.
- One sub-module: `pipe_sat_counter` (CNT_W-bit saturating increment/clear plus threshold compare), used for `stall_cnt_o`/`hang_o`.

## Test plan
- Load: `in_valid`=1, `in_data`={32'h4, 32'h8C010000, 32'h8}, no stall → next cycle `out_valid`=1 and `out_data` equal.
- Stall 3 cycles then release: outputs hold for 3 edges; `stall_cnt_o` goes 1, 2, 3, then 0 after release. Without skid, `in_ready`=0 during the stall.
- Stall+flush same cycle: `out_valid`=0, `out_data`=0, `stall_cnt_o`=0.
- `STALL_LIMIT`=4, `CNT_W`=3, stall 10 cycles → `hang_o` rises after the 4th edge. The counter saturates at 7.
- Skid (`PIPE_STAGE_SKID_EN`): word A loaded, then stall with word B valid → B captured and `in_ready`=0. Release → `out_data`=B one cycle later; A is not repeated.
- Async reset asserted between edges mid-stall with skid full → all outputs 0 immediately. `in_ready`=1 (skid) or `~stall_i` (no skid).
